retire_trace_buffer: RTL and testbench
======================================

// Module: retire_trace_buffer
// PURPOSE
//  Synthesizable commit-trace capture for the pipelined processor. Each cycle the
//  writeback stage retires an instruction, the block packs PC, register write,
//  memory access and halt into one record and numbers it. Records are buffered in
//  a DEPTH-entry FIFO and drained over a valid/ready port. Also keeps instruction
//  and cycle counters, detects halt and reports overflow or applies backpressure.
// PARAMETERS
//  DATA_W      16  width of PC, register data, memory address/data
//  REG_ADDR_W  3   register specifier width
//  DEPTH       16  FIFO entries; power of 2, >=2
//  CNT_W       32  width of inst/cycle/drop counters and record INUM field
//  FULL_POLICY 0   0 = drop on full; 1 = raise stall_req toward pipeline
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous active-high reset
//  cm_valid     in   1          an instruction retires this cycle
//  cm_pc        in   DATA_W     PC of retiring instruction
//  cm_reg_we    in   1          register file write
//  cm_wreg      in   REG_ADDR_W destination register
//  cm_wdata     in   DATA_W     register write data
//  cm_mem_re    in   1          memory read (load)
//  cm_mem_we    in   1          memory write (store)
//  cm_maddr     in   DATA_W     memory address
//  cm_mdata     in   DATA_W     store data
//  cm_halt      in   1          retiring instruction is HALT
//  stall_req    out  1          FULL_POLICY=1: hold retirement (FIFO full)
//  tr_valid     out  1          head record available
//  tr_ready     in   1          consumer accepts head record
//  tr_rec       out  REC_W      head record, REC_W = CNT_W+4*DATA_W+REG_ADDR_W+4
//  inst_count   out  CNT_W      retired instructions accepted
//  cycle_count  out  CNT_W      cycles since reset, frozen at halt
//  drop_count   out  CNT_W      records lost to full FIFO
//  overflow     out  1          sticky: at least one record dropped
//  halted       out  1          HALT retired
//  done         out  1          halted and FIFO drained
// BEHAVIOUR
//  - Reset: every output 0, FIFO empty, state RUN. Applies mid-operation; it
//    discards buffered records and clears counters and overflow.
//  - tr_rec layout, MSB->LSB: {INUM, PC, WDATA, MADDR, MDATA, WREG,
//    REG_WE, MEM_RE, MEM_WE, HALT}. INUM = inst_count before this accept (0-based).
//  - States: RUN -> HALTED on an accepted cm_valid&&cm_halt.
//    HALTED -> DRAINED when FIFO empty. DRAINED is held until rst.
//  - Accept: cm_valid in RUN. Each accept increments inst_count, stored or not.
//    cm_valid in HALTED/DRAINED is ignored.
//  - Push when !full, or when full and a pop happens in the same cycle
//    (tr_valid&&tr_ready).
//  - Full with no pop: drop record, drop_count+1, overflow<=1. Under
//    FULL_POLICY=1 this is a protocol violation and is handled the same way.
//  - stall_req = FULL_POLICY && full (from registered count). Tied 0 when
//    FULL_POLICY=0.
//  - Latency: a pushed record appears at tr_rec/tr_valid the cycle after push.
//    tr_valid = !empty. Head is stable while tr_valid && !tr_ready.
//  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//    full = MSBs differ and rest equal; empty = equal.
//  - cycle_count increments each cycle in RUN, including the halt-accept cycle,
//    then freezes. All counters wrap modulo 2^CNT_W.
//  - halted=1 in HALTED and DRAINED. done=1 only in DRAINED. Both registered.
// TESTING
//  - Reset, then 3 cm_valid (PC 0x0000/2/4, reg_we, wreg 1/2/3, wdata 0x0011..13),
//    tr_ready=1 -> 3 records with INUM 0,1,2; inst_count=3; overflow=0.
//  - DEPTH=4, FULL_POLICY=0, tr_ready=0, 6 accepts -> 4 records held (INUM 0-3),
//    drop_count=2, overflow=1, inst_count=6.
//  - FULL_POLICY=1, DEPTH=4, tr_ready=0 -> stall_req=1 the cycle after the 4th
//    push. One pop -> stall_req=0 next cycle.
//  - Full FIFO with push and pop in same cycle -> no drop, count stays 4,
//    order preserved.
//  - HALT at PC 0x0010 on cycle 20 with 2 records queued -> halted=1 next cycle,
//    cycle_count frozen at 20, later cm_valid ignored, done=1 after 3rd pop.
//  - rst pulse with 3 records queued -> tr_valid=0 and counters 0 next cycle;
//    state RUN.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Commit-trace capture for the pipelined processor. Every instruction that
//   retires from writeback is packed into one numbered record and queued in a
//   DEPTH-entry FIFO. The queue drains over a valid/ready port. The block also
//   keeps instruction, cycle and drop counters, tracks HALT, and reports
//   overflow or asks the pipeline to stall.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   cm_*           retirement interface: valid, pc, reg write (we/wreg/wdata),
//                  memory access (re/we/maddr/mdata) and halt
//   stall_req      FIFO full; only driven when FULL_POLICY=1, otherwise 0
//   tr_valid       a head record is available
//   tr_ready       the consumer takes the head record this cycle
//   tr_rec         head record, MSB->LSB:
//                  {INUM, PC, WDATA, MADDR, MDATA, WREG, REG_WE, MEM_RE, MEM_WE, HALT}
//   inst_count     accepted retirements
//   cycle_count    cycles spent running since reset, frozen once HALT retires
//   drop_count     records lost because the FIFO was full
//   overflow       sticky flag, set when any record has been dropped
//   halted         a HALT has retired
//   done           halted and the FIFO has drained
module retire_trace_buffer #(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 3,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int FULL_POLICY = 0,
  localparam int REC_W      = CNT_W + 4*DATA_W + REG_ADDR_W + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cm_valid,
  input  logic [DATA_W-1:0]     cm_pc,
  input  logic                  cm_reg_we,
  input  logic [REG_ADDR_W-1:0] cm_wreg,
  input  logic [DATA_W-1:0]     cm_wdata,
  input  logic                  cm_mem_re,
  input  logic                  cm_mem_we,
  input  logic [DATA_W-1:0]     cm_maddr,
  input  logic [DATA_W-1:0]     cm_mdata,
  input  logic                  cm_halt,
  output logic                  stall_req,
  output logic                  tr_valid,
  input  logic                  tr_ready,
  output logic [REC_W-1:0]      tr_rec,
  output logic [CNT_W-1:0]      inst_count,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  overflow,
  output logic                  halted,
  output logic                  done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] HALTED  = 2'd1;
  localparam logic [1:0] DRAINED = 2'd2;

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [REC_W-1:0] recMem [DEPTH];
  logic [REC_W-1:0] newRec;
  logic             isEmpty;
  logic             isFull;
  logic             accept;
  logic             pop;
  logic             push;
  logic             drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy counter.
  assign isEmpty = (wrPtr == rdPtr);
  assign isFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  assign accept = cm_valid && (state == RUN);
  assign pop    = !isEmpty && tr_ready;
  // A full FIFO can still take the new record when the head leaves this cycle.
  assign push   = accept && (!isFull || pop);
  assign drop   = accept && isFull && !pop;

  // INUM is the count before this accept, so numbering starts at 0.
  assign newRec = {inst_count, cm_pc, cm_wdata, cm_maddr, cm_mdata, cm_wreg,
                   cm_reg_we, cm_mem_re, cm_mem_we, cm_halt};

  assign tr_valid = !isEmpty;
  // Gated so stale storage never shows on the port while nothing is queued.
  assign tr_rec   = isEmpty ? '0 : recMem[rdPtr[AW-1:0]];

  generate
    if (FULL_POLICY != 0) begin : gStall
      assign stall_req = isFull;
    end else begin : gNoStall
      assign stall_req = 1'b0;
    end
  endgenerate

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (accept && cm_halt) stateNext = HALTED;
      HALTED:  if (isEmpty) stateNext = DRAINED;
      DRAINED: stateNext = DRAINED;
      default: stateNext = RUN;
    endcase
  end

  // ---- control register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wrPtr       <= '0;
      rdPtr       <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      halted      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state  <= stateNext;
      halted <= (stateNext != RUN);
      done   <= (stateNext == DRAINED);
      if (push) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
      if (accept) inst_count <= inst_count + CNT_W'(1);
      // The halt-accept cycle still counts; the freeze starts the cycle after.
      if (state == RUN) cycle_count <= cycle_count + CNT_W'(1);
      if (drop) begin
        drop_count <= drop_count + CNT_W'(1);
        overflow   <= 1'b1;
      end
    end
  end

  // ---- record storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push) recMem[wrPtr[AW-1:0]] <= newRec;
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: two DEPTH=4 instances (drop policy and stall
// policy) share one stimulus stream and are compared against a queue-based
// reference model after every clock.
module tb_retire_trace_buffer;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = 32;
  localparam int REC_W      = CNT_W + 4*DATA_W + REG_ADDR_W + 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cm_valid = 1'b0;
  logic [DATA_W-1:0]     cm_pc = '0;
  logic                  cm_reg_we = 1'b0;
  logic [REG_ADDR_W-1:0] cm_wreg = '0;
  logic [DATA_W-1:0]     cm_wdata = '0;
  logic                  cm_mem_re = 1'b0;
  logic                  cm_mem_we = 1'b0;
  logic [DATA_W-1:0]     cm_maddr = '0;
  logic [DATA_W-1:0]     cm_mdata = '0;
  logic                  cm_halt = 1'b0;
  logic                  tr_ready = 1'b0;

  logic                  stallA, stallB, tvA, tvB, ovA, ovB, hA, hB, dA, dB;
  logic [REC_W-1:0]      recA, recB;
  logic [CNT_W-1:0]      icA, icB, ccA, ccB, dcA, dcB;

  int checks = 0;
  int failures = 0;

  // reference model
  logic [REC_W-1:0] mq[$];
  logic [CNT_W-1:0] mInst = '0, mCycle = '0, mDrop = '0;
  bit               mOv = 0, mHalted = 0, mDone = 0;

  always #5 clk = ~clk;

  retire_trace_buffer #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH),
                        .CNT_W(CNT_W), .FULL_POLICY(0)) dutA (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_reg_we(cm_reg_we),
    .cm_wreg(cm_wreg), .cm_wdata(cm_wdata), .cm_mem_re(cm_mem_re), .cm_mem_we(cm_mem_we),
    .cm_maddr(cm_maddr), .cm_mdata(cm_mdata), .cm_halt(cm_halt), .stall_req(stallA),
    .tr_valid(tvA), .tr_ready(tr_ready), .tr_rec(recA), .inst_count(icA),
    .cycle_count(ccA), .drop_count(dcA), .overflow(ovA), .halted(hA), .done(dA));

  retire_trace_buffer #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH),
                        .CNT_W(CNT_W), .FULL_POLICY(1)) dutB (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_reg_we(cm_reg_we),
    .cm_wreg(cm_wreg), .cm_wdata(cm_wdata), .cm_mem_re(cm_mem_re), .cm_mem_we(cm_mem_we),
    .cm_maddr(cm_maddr), .cm_mdata(cm_mdata), .cm_halt(cm_halt), .stall_req(stallB),
    .tr_valid(tvB), .tr_ready(tr_ready), .tr_rec(recB), .inst_count(icB),
    .cycle_count(ccB), .drop_count(dcB), .overflow(ovB), .halted(hB), .done(dB));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of the specified behaviour, written over the queue.
  task automatic modelClock();
    int  sz;
    bit  pop, acc;
    logic [REC_W-1:0] rec;
    if (rst) begin
      mq.delete();
      mInst = '0; mCycle = '0; mDrop = '0;
      mOv = 0; mHalted = 0; mDone = 0;
      return;
    end
    sz  = mq.size();
    pop = (sz != 0) && tr_ready;
    acc = cm_valid && !mHalted;
    rec = {mInst, cm_pc, cm_wdata, cm_maddr, cm_mdata, cm_wreg,
           cm_reg_we, cm_mem_re, cm_mem_we, cm_halt};
    if (mHalted && sz == 0) mDone = 1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      if (sz < DEPTH || pop) mq.push_back(rec);
      else begin
        mDrop = mDrop + 1;
        mOv   = 1;
      end
      mInst = mInst + 1;
    end
    if (!mHalted) mCycle = mCycle + 1;
    if (acc && cm_halt) mHalted = 1;
  endtask

  task automatic chkOne(input string who, input logic tv, input logic [REC_W-1:0] rec,
                        input logic [CNT_W-1:0] ic, input logic [CNT_W-1:0] cc,
                        input logic [CNT_W-1:0] dc, input logic ov, input logic h,
                        input logic d, input logic st, input logic expSt);
    logic [REC_W-1:0] expRec;
    expRec = (mq.size() != 0) ? mq[0] : '0;
    chk({who, "_tr_valid"}, tv, mq.size() != 0);
    chk({who, "_tr_rec"}, rec, expRec);
    chk({who, "_inst_count"}, ic, mInst);
    chk({who, "_cycle_count"}, cc, mCycle);
    chk({who, "_drop_count"}, dc, mDrop);
    chk({who, "_overflow"}, ov, mOv);
    chk({who, "_halted"}, h, mHalted);
    chk({who, "_done"}, d, mDone);
    chk({who, "_stall_req"}, st, expSt);
  endtask

  task automatic step(input bit r, input bit v, input bit h, input bit rdy);
    rst = r; cm_valid = v; cm_halt = h; tr_ready = rdy;
    @(posedge clk);
    modelClock();
    #1;
    chkOne("A", tvA, recA, icA, ccA, dcA, ovA, hA, dA, stallA, 1'b0);
    chkOne("B", tvB, recB, icB, ccB, dcB, ovB, hB, dB, stallB, mq.size() == DEPTH);
  endtask

  task automatic randData();
    cm_pc     = DATA_W'($urandom);
    cm_reg_we = 1'($urandom);
    cm_wreg   = REG_ADDR_W'($urandom);
    cm_wdata  = DATA_W'($urandom);
    cm_mem_re = 1'($urandom);
    cm_mem_we = 1'($urandom);
    cm_maddr  = DATA_W'($urandom);
    cm_mdata  = DATA_W'($urandom);
  endtask

  initial begin
    logic [REC_W-1:0] firstRec;
    int guard;

    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_tr_valid", tvA, 1'b0);
    chk("reset_tr_rec", recA, '0);

    // three simple register-writing retirements, consumer always ready
    for (int i = 0; i < 3; i++) begin
      cm_pc = DATA_W'(2*i); cm_reg_we = 1'b1; cm_wreg = REG_ADDR_W'(i+1);
      cm_wdata = DATA_W'(16'h0011 + i); cm_mem_re = 1'b0; cm_mem_we = 1'b0;
      cm_maddr = '0; cm_mdata = '0;
      step(0, 1, 0, 1);
      if (i == 0) begin
        firstRec = {32'd0, 16'h0000, 16'h0011, 16'h0000, 16'h0000, 3'd1,
                    1'b1, 1'b0, 1'b0, 1'b0};
        chk("t1_first_rec", recA, firstRec);
      end
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("t1_inst_count", icA, 32'd3);
    chk("t1_overflow", ovA, 1'b0);

    // overflow with the consumer stalled
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      randData();
      step(0, 1, 0, 0);
    end
    chk("t2_drop_count", dcA, 32'd2);
    chk("t2_overflow", ovA, 1'b1);
    chk("t2_inst_count", icA, 32'd6);
    chk("t2_head_inum", recA[REC_W-1 -: CNT_W], 32'd0);
    chk("t2_stall_full", stallB, 1'b1);

    // push and pop together while full: no loss
    for (int i = 0; i < 3; i++) begin
      randData();
      step(0, 1, 0, 1);
    end
    chk("t3_drop_same", dcA, 32'd2);
    chk("t3_head_inum", recA[REC_W-1 -: CNT_W], 32'd3);

    // single pop releases the stall
    step(0, 0, 0, 1);
    chk("t4_stall_released", stallB, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // random traffic with occasional halts and resets
    step(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      randData();
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 50);
    end

    // HALT on cycle 20 with two records already queued
    step(1, 0, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      randData();
      if (c == 20) cm_pc = 16'h0010;
      step(0, c >= 18, c == 20, 0);
    end
    chk("t5_halted", hA, 1'b1);
    chk("t5_cycle_frozen", ccA, 32'd20);
    randData();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("t5_ignored_inst", icA, 32'd3);
    chk("t5_cycle_still", ccA, 32'd20);
    guard = 0;
    while (!dA && guard < 10) begin
      step(0, 0, 0, 1);
      guard++;
    end
    chk("t5_done", dA, 1'b1);
    chk("t5_drained", tvA, 1'b0);

    // reset with records queued
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      randData();
      step(0, 1, 0, 0);
    end
    step(1, 0, 0, 0);
    chk("t6_tr_valid", tvA, 1'b0);
    chk("t6_inst_count", icA, 32'd0);
    chk("t6_halted", hA, 1'b0);
    randData();
    step(0, 1, 0, 0);
    chk("t6_run_again", icA, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
